// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks (referee, column lights and pipes).
//   state_e   : referee game state (IDLE / PLAY / OVER)
//   ROWS      : default number of rows in a light column
//   SCORE_MAX : highest reachable score; the score counter saturates here
//   SCORE_W   : width of the score bus
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int unsigned ROWS      = 8;
  localparam int unsigned SCORE_MAX = 99;
  localparam int unsigned SCORE_W   = 7;

endpackage

// File: rtl/tick_divider.sv
// Game tick divider: counts 0..TICK_DIV-1 while run is high and wraps.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   run   : count enable; low clears the count to 0
//   tick  : high for the single cycle in which the count equals TICK_DIV-1
module tick_divider #(
  parameter int unsigned TICK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear when stopped, wrap at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the registered count; gated by run so a stale count never ticks.
  assign tick = run && (cnt_q == CNT_MAX);

endmodule

// File: rtl/game_referee.sv
// Flappy game referee: start/crash FSM, game tick generation, flap capture and score.
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   key_up      : synchronized flap key level, 1 = pressed
//   bird_col    : lit pixels of the bird column, bit 0 = bottom row
//   pipe_col    : pipe pixels in the bird column, bit 0 = bottom row
//   pipe_passed : one-cycle pulse when a pipe leaves the bird column
//   enable      : one-cycle game tick to all column lights
//   up          : flap command, meaningful only while enable = 1
//   gameOver    : sticky crash flag
//   score       : pipes cleared, saturating at SCORE_MAX
module game_referee #(
  parameter int unsigned TICK_DIV = 8,
  parameter int unsigned ROWS     = flappy_pkg::ROWS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key_up,
  input  logic [ROWS-1:0]                bird_col,
  input  logic [ROWS-1:0]                pipe_col,
  input  logic                           pipe_passed,
  output logic                           enable,
  output logic                           up,
  output logic                           gameOver,
  output logic [flappy_pkg::SCORE_W-1:0] score
);

  import flappy_pkg::*;

  state_e             state_q;
  state_e             state_d;
  logic               key_prev_q;
  logic               pending_q;
  logic               pending_d;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;

  logic key_rise;
  logic collide;
  logic run;
  logic tick;

  assign key_rise = key_up & ~key_prev_q;

  // A crash is any overlap with a pipe, or the bird having left the column entirely.
  assign collide = ((bird_col & pipe_col) != '0) || (bird_col == '0);

  assign run = (state_q == PLAY);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  // Next-state, flap capture, score and output decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    score_d   = score_q;
    enable    = 1'b0;
    up        = 1'b0;
    gameOver  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The starting key press is consumed here and never becomes a flap.
        pending_d = 1'b0;
        if (key_rise) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        // The tick of a crashing cycle still goes out before the move to OVER.
        enable = tick;
        up     = tick & (pending_q | key_rise);
        if (tick) begin
          pending_d = 1'b0;
        end else if (key_rise) begin
          pending_d = 1'b1;
        end

        if (collide) begin
          state_d = OVER;
        end else if (pipe_passed && (score_q < SCORE_W'(SCORE_MAX))) begin
          score_d = score_q + SCORE_W'(1);
        end
      end

      OVER: begin
        gameOver  = 1'b1;
        pending_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      key_prev_q <= 1'b0;
      pending_q  <= 1'b0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_up;
      pending_q  <= pending_d;
      score_q    <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: tb/tb_game_referee.sv
// Self-checking bench for game_referee: directed scenarios followed by random play,
// all compared against a cycle-level behavioural model of the game rules.
module tb_game_referee;

  localparam int TICK      = 4;
  localparam int ROWS      = 8;
  localparam int SCORE_MAX = 99;

  logic            clk = 1'b0;
  logic            reset;
  logic            key_up;
  logic [ROWS-1:0] bird_col;
  logic [ROWS-1:0] pipe_col;
  logic            pipe_passed;
  logic            enable;
  logic            up;
  logic            gameOver;
  logic [6:0]      score;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: playing/over flags, cycles spent in play, pending flap, last key, score.
  bit m_play;
  bit m_over;
  bit m_pend;
  bit m_prev;
  int m_age;
  int m_score;

  localparam logic [ROWS-1:0] SAFE_BIRD = 8'h10;
  localparam logic [ROWS-1:0] NO_PIPE   = 8'h00;
  localparam logic [ROWS-1:0] GAP_PIPE  = 8'hC3;

  game_referee #(
    .TICK_DIV (TICK),
    .ROWS     (ROWS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_up      (key_up),
    .bird_col    (bird_col),
    .pipe_col    (pipe_col),
    .pipe_passed (pipe_passed),
    .enable      (enable),
    .up          (up),
    .gameOver    (gameOver),
    .score       (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_play  = 1'b0;
    m_over  = 1'b0;
    m_pend  = 1'b0;
    m_prev  = 1'b0;
    m_age   = 0;
    m_score = 0;
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, advance the model.
  task automatic step(input bit rst, input bit key, input logic [ROWS-1:0] bird,
                      input logic [ROWS-1:0] pipe, input bit passed);
    bit rise;
    bit e_en;
    bit e_up;
    reset       = rst;
    key_up      = key;
    bird_col    = bird;
    pipe_col    = pipe;
    pipe_passed = passed;
    #3;
    rise = key && !m_prev;
    // Every TICK-th cycle of play carries a tick, the first one TICK cycles after the start.
    e_en = m_play && ((m_age % TICK) == 0);
    e_up = e_en && (m_pend || rise);
    check("enable",   32'(enable),   32'(e_en));
    check("up",       32'(up),       32'(e_up));
    check("gameOver", 32'(gameOver), 32'(m_over));
    check("score",    32'(score),    32'(m_score));

    if (rst) begin
      model_reset();
    end else begin
      if (m_play) begin
        m_pend = e_en ? 1'b0 : (m_pend || rise);
        m_age++;
        if (((bird & pipe) != '0) || (bird == '0)) begin
          m_play = 1'b0;
          m_over = 1'b1;
        end else if (passed && (m_score < SCORE_MAX)) begin
          m_score++;
        end
      end else if (!m_over && rise) begin
        m_play = 1'b1;
        m_age  = 1;
      end
      m_prev = key;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit k;
    logic [ROWS-1:0] b;
    logic [ROWS-1:0] p;

    reset       = 1'b1;
    key_up      = 1'b0;
    bird_col    = SAFE_BIRD;
    pipe_col    = NO_PIPE;
    pipe_passed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Idle with the key released: no ticks, no score even with pipe pulses.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, (i % 5) == 0);
    check("idle_score", 32'(score), 32'd0);

    // Start the game and watch three ticks with no flap.
    step(1'b0, 1'b1, SAFE_BIRD, NO_PIPE, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, SAFE_BIRD, GAP_PIPE, 1'b0);

    // Align to the cycle just after a tick, then two presses between ticks.
    for (int i = 0; i < TICK && (m_age % TICK) != 1; i++)
      step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b1, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b1, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);
    for (int i = 0; i < TICK; i++) step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);

    // Clear 101 pipes: score saturates.
    for (int i = 0; i < 101; i++) begin
      step(1'b0, 1'b0, SAFE_BIRD, GAP_PIPE, 1'b1);
      step(1'b0, 1'b0, SAFE_BIRD, GAP_PIPE, 1'b0);
    end
    check("score_sat", 32'(score), 32'(SCORE_MAX));

    // Crash together with a pipe pulse, then sit in OVER with random inputs.
    step(1'b0, 1'b0, 8'h01, 8'h03, 1'b1);
    check("crash_over", 32'(gameOver), 32'd1);
    for (int i = 0; i < 50; i++)
      step(1'b0, 1'($urandom_range(1)), 8'h01, 8'h03, 1'($urandom_range(1)));

    // Reset out of OVER, restart, reset mid-count, restart again.
    step(1'b1, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b1, SAFE_BIRD, NO_PIPE, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b1);
    step(1'b1, 1'b1, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b0);
    step(1'b0, 1'b1, SAFE_BIRD, NO_PIPE, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, SAFE_BIRD, NO_PIPE, 1'b1);

    // Random play with occasional crashes and resets.
    k = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      b = ROWS'(1) << $urandom_range(ROWS - 1);
      p = ROWS'($urandom) & ~b;
      if ($urandom_range(39) == 0) p = ROWS'($urandom);
      if ($urandom_range(199) == 0) b = '0;
      if ($urandom_range(2) == 0) k = ~k;
      step(m_over ? ($urandom_range(9) == 0) : ($urandom_range(499) == 0),
           k, b, p, $urandom_range(3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_referee.md
GAME_REFEREE -- requirements
Module: game_referee

Interface
REQ-001 Parameter: TICK_DIV, default 8, clock cycles per game tick (min 2).
REQ-002 Parameter: ROWS, default 8, number of rows in the bird column.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_up  in  1  flap key level, already synchronized, 1 = pressed.
REQ-006 bird_col  in  ROWS  lightOn vector of the bird column; bit 0 = bottom row.
REQ-007 pipe_col  in  ROWS  pipe pixels currently in the bird column; bit 0 = bottom row.
REQ-008 pipe_passed  in  1  one-cycle pulse when a pipe leaves the bird column.
REQ-009 enable  out  1  one-cycle game tick to all column lights.
REQ-010 up  out  1  flap command to the bird lights; valid only while enable = 1.
REQ-011 gameOver  out  1  sticky crash flag to all lights.
REQ-012 score  out  7  pipes cleared, binary, range 0..99.

Function
REQ-013 FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-014 IDLE: enable = 0, up = 0, gameOver = 0, and the divider is held at 0.
REQ-015 IDLE -> PLAY on a rising edge of key_up (key_up = 1 while the previous sampled value = 0); this edge SHALL NOT create a pending flap.
REQ-016 PLAY: the divider counts 0..TICK_DIV-1 and wraps; enable = 1 for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-017 The first enable pulse after entering PLAY SHALL occur TICK_DIV cycles after the transition cycle.
REQ-018 Flap capture: a key_up rising edge in PLAY sets a pending flag; multiple edges between ticks count as one flap.
REQ-019 up = enable AND (pending OR a rising edge in the same cycle); pending clears on every enable cycle.
REQ-020 Collision: in PLAY, if (bird_col AND pipe_col) != 0 or bird_col == 0, the FSM SHALL move to OVER on the next edge.
REQ-021 A collision in the same cycle as an enable pulse SHALL still let that pulse and its up value be output, then move to OVER.
REQ-022 OVER: gameOver = 1, enable = 0, up = 0, score frozen; key_up ignored; exit only by reset.
REQ-023 Score: in PLAY, a pipe_passed pulse with no collision in the same cycle increments score by 1 on the next edge.
REQ-024 Score saturates at 99; further pipe_passed pulses leave it at 99.
REQ-025 Collision and pipe_passed in the same cycle: the collision wins and score is unchanged.
REQ-026 pipe_passed in IDLE or OVER SHALL be ignored.
REQ-027 All outputs are registered or decoded from registered state only (no combinational path from bird_col or pipe_col to any output), except that up may also depend on key_up per REQ-019.

Reset
REQ-028 reset SHALL force state = IDLE, divider = 0, pending = 0, previous-key register = 0, score = 0, enable = 0, up = 0, gameOver = 0 on the next edge.
REQ-029 reset SHALL take priority over every other event, including one asserted mid-tick or in OVER; the block restarts in IDLE.

Structure
REQ-030 Package flappy_pkg SHALL hold the state enum (IDLE/PLAY/OVER), ROWS, and SCORE_MAX = 99, shared with the light and pipe modules.
REQ-031 The divider SHALL be a sub-module tick_divider with ports clk, reset, run, and tick; run = 0 clears the count.
REQ-032 Edge detection, flap capture, FSM and score counter stay in game_referee.

Verification
REQ-033 Scenario: reset, hold key_up = 0 for 20 cycles -> enable never 1, gameOver = 0, score = 0.
REQ-034 Scenario: TICK_DIV = 4, press key_up once in IDLE -> PLAY; enable pulses every 4th cycle starting 4 cycles after the transition; first tick up = 0.
REQ-035 Scenario: in PLAY, pulse key_up twice between two ticks -> exactly one tick with up = 1, next tick up = 0.
REQ-036 Scenario: bird_col = 8'b0000_0001, pipe_col = 8'b0000_0011 -> gameOver = 1 on the next cycle; enable stays 0 for 50 cycles; score frozen.
REQ-037 Scenario: 101 clean pipe_passed pulses -> score reaches 99 and stays 99; then a pipe_passed pulse in the same cycle as a collision -> score unchanged, gameOver = 1.
REQ-038 Scenario: reset asserted in OVER and mid-divider count -> next cycle all outputs 0, state IDLE; a new key press restarts the game normally.
